// File: rtl/sys_bus_arb.sv
// Two-master, N-slave registered MMIO interconnect with round-robin arbitration,
// region address decode, slave wait states, a ready timeout and an error response.
module sys_bus_arb #(
  parameter int                NUM_SLAVES   = 4,
  parameter int                ADDR_W       = 64,
  parameter int                DATA_W       = 64,
  parameter logic [ADDR_W-1:0] BUS_BASE     = 64'h1000_0000,
  parameter int                REGION_SHIFT = 12,
  parameter int                TIMEOUT_CYC  = 255
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         m0_req,
  input  logic [ADDR_W-1:0]            m0_addr,
  input  logic [DATA_W-1:0]            m0_din,
  input  logic [2:0]                   m0_rd_ctrl,
  input  logic [2:0]                   m0_wr_ctrl,
  output logic                         m0_ack,
  output logic [DATA_W-1:0]            m0_dout,
  output logic                         m0_err,
  input  logic                         m1_req,
  input  logic [ADDR_W-1:0]            m1_addr,
  input  logic [DATA_W-1:0]            m1_din,
  input  logic [2:0]                   m1_rd_ctrl,
  input  logic [2:0]                   m1_wr_ctrl,
  output logic                         m1_ack,
  output logic [DATA_W-1:0]            m1_dout,
  output logic                         m1_err,
  output logic [NUM_SLAVES-1:0]        s_sel,
  output logic [ADDR_W-1:0]            s_addr,
  output logic [DATA_W-1:0]            s_din,
  output logic [2:0]                   s_rd_ctrl,
  output logic [2:0]                   s_wr_ctrl,
  input  logic [NUM_SLAVES*DATA_W-1:0] s_dout,
  input  logic [NUM_SLAVES-1:0]        s_ready
);

  localparam int IDX_W  = $clog2(NUM_SLAVES);
  localparam int TAG_LO = REGION_SHIFT + IDX_W;
  localparam int CNT_W  = $clog2(TIMEOUT_CYC + 1);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t                  state, state_nxt;
  logic                    last_grant, last_grant_nxt;
  logic                    grant_id, grant_id_nxt;
  logic [CNT_W-1:0]        cnt, cnt_nxt;
  logic [NUM_SLAVES-1:0]   sel_nxt;
  logic [ADDR_W-1:0]       addr_nxt;
  logic [DATA_W-1:0]       din_nxt;
  logic [2:0]              rd_nxt, wr_nxt;
  logic                    ack0_nxt, ack1_nxt, err0_nxt, err1_nxt;
  logic [DATA_W-1:0]       dout0_nxt, dout1_nxt;

  // Arbitration and decode of the candidate master in IDLE
  logic                    pick;
  logic [ADDR_W-1:0]       pick_addr;
  logic [DATA_W-1:0]       pick_din;
  logic [2:0]              pick_rd, pick_wr;
  logic                    pick_hit, pick_null;
  logic [IDX_W-1:0]        pick_idx;

  // Selected slave, recovered from the latched address
  logic [IDX_W-1:0]        cur_idx;
  logic                    cur_ready;
  logic [DATA_W-1:0]       cur_data;

  logic                    resp_go, resp_tgt, resp_err;
  logic [DATA_W-1:0]       resp_data;

  assign pick      = (m0_req && m1_req) ? ~last_grant : m1_req;
  assign pick_addr = pick ? m1_addr    : m0_addr;
  assign pick_din  = pick ? m1_din     : m0_din;
  assign pick_rd   = pick ? m1_rd_ctrl : m0_rd_ctrl;
  assign pick_wr   = pick ? m1_wr_ctrl : m0_wr_ctrl;
  assign pick_hit  = (pick_addr[ADDR_W-1:TAG_LO] == BUS_BASE[ADDR_W-1:TAG_LO]);
  assign pick_null = (pick_rd == 3'd0) && (pick_wr == 3'd0);
  assign pick_idx  = pick_addr[TAG_LO-1:REGION_SHIFT];

  assign cur_idx   = s_addr[TAG_LO-1:REGION_SHIFT];
  assign cur_ready = s_ready[cur_idx];
  assign cur_data  = s_dout[cur_idx*DATA_W +: DATA_W];

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      last_grant <= 1'b1;
      grant_id   <= 1'b0;
      cnt        <= '0;
      s_sel      <= '0;
      s_addr     <= '0;
      s_din      <= '0;
      s_rd_ctrl  <= 3'd0;
      s_wr_ctrl  <= 3'd0;
      m0_ack     <= 1'b0;
      m0_dout    <= '0;
      m0_err     <= 1'b0;
      m1_ack     <= 1'b0;
      m1_dout    <= '0;
      m1_err     <= 1'b0;
    end else begin
      state      <= state_nxt;
      last_grant <= last_grant_nxt;
      grant_id   <= grant_id_nxt;
      cnt        <= cnt_nxt;
      s_sel      <= sel_nxt;
      s_addr     <= addr_nxt;
      s_din      <= din_nxt;
      s_rd_ctrl  <= rd_nxt;
      s_wr_ctrl  <= wr_nxt;
      m0_ack     <= ack0_nxt;
      m0_dout    <= dout0_nxt;
      m0_err     <= err0_nxt;
      m1_ack     <= ack1_nxt;
      m1_dout    <= dout1_nxt;
      m1_err     <= err1_nxt;
    end
  end

  always_comb begin
    state_nxt      = state;
    last_grant_nxt = last_grant;
    grant_id_nxt   = grant_id;
    cnt_nxt        = cnt;
    sel_nxt        = s_sel;
    addr_nxt       = s_addr;
    din_nxt        = s_din;
    rd_nxt         = s_rd_ctrl;
    wr_nxt         = s_wr_ctrl;
    ack0_nxt       = m0_ack;
    ack1_nxt       = m1_ack;
    err0_nxt       = m0_err;
    err1_nxt       = m1_err;
    dout0_nxt      = m0_dout;
    dout1_nxt      = m1_dout;
    resp_go        = 1'b0;
    resp_tgt       = grant_id;
    resp_err       = 1'b0;
    resp_data      = '0;

    unique case (state)
      IDLE: begin
        if (m0_req || m1_req) begin
          grant_id_nxt = pick;
          addr_nxt     = pick_addr;
          din_nxt      = pick_din;
          // A combined read+write request is carried out as a write only
          rd_nxt       = (pick_wr != 3'd0) ? 3'd0 : pick_rd;
          wr_nxt       = pick_wr;
          if (pick_hit && !pick_null) begin
            sel_nxt   = NUM_SLAVES'(1) << pick_idx;
            state_nxt = WAIT;
          end else begin
            resp_go   = 1'b1;
            resp_tgt  = pick;
            resp_err  = 1'b1;
          end
        end
      end

      WAIT: begin
        cnt_nxt = cnt + CNT_W'(1);
        // Ready takes priority over a timeout reached in the same cycle
        if (cur_ready) begin
          resp_go   = 1'b1;
          resp_data = (s_wr_ctrl != 3'd0) ? '0 : cur_data;
          sel_nxt   = '0;
        end else if (cnt == CNT_W'(TIMEOUT_CYC)) begin
          resp_go  = 1'b1;
          resp_err = 1'b1;
          sel_nxt  = '0;
        end
      end

      RESP: begin
        ack0_nxt       = 1'b0;
        ack1_nxt       = 1'b0;
        err0_nxt       = 1'b0;
        err1_nxt       = 1'b0;
        dout0_nxt      = '0;
        dout1_nxt      = '0;
        last_grant_nxt = grant_id;
        cnt_nxt        = '0;
        state_nxt      = IDLE;
      end

      default: state_nxt = IDLE;
    endcase

    if (resp_go) begin
      state_nxt = RESP;
      if (resp_tgt) begin
        ack1_nxt  = 1'b1;
        err1_nxt  = resp_err;
        dout1_nxt = resp_data;
      end else begin
        ack0_nxt  = 1'b1;
        err0_nxt  = resp_err;
        dout0_nxt = resp_data;
      end
    end
  end

endmodule

// File: tb/tb_sys_bus_arb.sv
// Scoreboard bench for sys_bus_arb: directed transactions push expected acks,
// a negedge monitor pops and compares them as the DUT acknowledges.
module tb_sys_bus_arb;

  logic          clk = 1'b0;
  logic          rst;
  logic          m0_req, m1_req;
  logic [63:0]   m0_addr, m1_addr, m0_din, m1_din;
  logic [2:0]    m0_rd_ctrl, m0_wr_ctrl, m1_rd_ctrl, m1_wr_ctrl;
  logic          m0_ack, m1_ack, m0_err, m1_err;
  logic [63:0]   m0_dout, m1_dout;
  logic [3:0]    s_sel;
  logic [63:0]   s_addr, s_din;
  logic [2:0]    s_rd_ctrl, s_wr_ctrl;
  logic [255:0]  s_dout;
  logic [3:0]    s_ready;

  typedef struct {
    bit          mst;
    logic [63:0] dout;
    bit          err;
    int          cyc;
  } exp_t;

  exp_t        sb[$];
  int          checks = 0;
  int          failures = 0;
  int          cyc = 0;
  int          wait_cfg [4];
  logic [63:0] rd_data [4];
  logic [3:0]  stray = 4'b0000;

  sys_bus_arb #(.TIMEOUT_CYC(8)) dut (
    .clk(clk), .rst(rst),
    .m0_req(m0_req), .m0_addr(m0_addr), .m0_din(m0_din),
    .m0_rd_ctrl(m0_rd_ctrl), .m0_wr_ctrl(m0_wr_ctrl),
    .m0_ack(m0_ack), .m0_dout(m0_dout), .m0_err(m0_err),
    .m1_req(m1_req), .m1_addr(m1_addr), .m1_din(m1_din),
    .m1_rd_ctrl(m1_rd_ctrl), .m1_wr_ctrl(m1_wr_ctrl),
    .m1_ack(m1_ack), .m1_dout(m1_dout), .m1_err(m1_err),
    .s_sel(s_sel), .s_addr(s_addr), .s_din(s_din),
    .s_rd_ctrl(s_rd_ctrl), .s_wr_ctrl(s_wr_ctrl),
    .s_dout(s_dout), .s_ready(s_ready)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Slave model: slave i raises ready after wait_cfg[i] cycles of continuous select
  initial begin
    int   cnt [4];
    logic [3:0] prev;
    prev = 4'b0000;
    s_ready = 4'b0000;
    forever begin
      @(posedge clk); #1;
      for (int i = 0; i < 4; i++) begin
        s_dout[i*64 +: 64] = rd_data[i];
        if (s_sel[i]) cnt[i] = prev[i] ? cnt[i] + 1 : 0;
        s_ready[i] = (s_sel[i] && cnt[i] == wait_cfg[i]) || stray[i];
      end
      prev = s_sel;
    end
  end

  always @(negedge clk) begin
    if (!rst) begin
      checks++;
      if (m0_ack && m1_ack) begin
        failures++;
        $display("[TB] FAIL dual_ack actual=both required=one at cycle %0d", cyc);
      end else if (m0_ack || m1_ack) begin
        if (sb.size() == 0) begin
          failures++;
          $display("[TB] FAIL unexpected_ack actual=m%0d_ack required=none at cycle %0d", m1_ack, cyc);
        end else begin
          exp_t e;
          e = sb.pop_front();
          if (m1_ack != e.mst || (m1_ack ? m1_dout : m0_dout) !== e.dout ||
              (m1_ack ? m1_err : m0_err) !== e.err || cyc != e.cyc) begin
            failures++;
            $display("[TB] FAIL ack_resp actual=m%0d dout=%h err=%0b cyc=%0d required=m%0d dout=%h err=%0b cyc=%0d",
                     m1_ack, m1_ack ? m1_dout : m0_dout, m1_ack ? m1_err : m0_err, cyc,
                     e.mst, e.dout, e.err, e.cyc);
          end
        end
      end else if ({m0_dout, m1_dout, m0_err, m1_err} !== '0) begin
        failures++;
        $display("[TB] FAIL idle_resp actual=%h/%h/%b%b required=0", m0_dout, m1_dout, m0_err, m1_err);
      end
    end
  end

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic driveMaster(input bit mst, input bit req, input logic [63:0] addr, din,
                             input logic [2:0] rd, wr);
    if (mst) begin
      m1_req = req; m1_addr = addr; m1_din = din; m1_rd_ctrl = rd; m1_wr_ctrl = wr;
    end else begin
      m0_req = req; m0_addr = addr; m0_din = din; m0_rd_ctrl = rd; m0_wr_ctrl = wr;
    end
  endtask

  task automatic applyStimulus(input string name, input bit mst, input logic [63:0] addr, din,
                               input logic [2:0] rd, wr, input logic [63:0] exp_dout,
                               input bit exp_err, input int lat, input logic [3:0] exp_sel);
    int issue, sel_cycles;
    bit done;
    @(posedge clk); #1;
    driveMaster(mst, 1'b1, addr, din, rd, wr);
    issue = cyc;
    sb.push_back('{mst, exp_dout, exp_err, issue + lat});
    sel_cycles = 0;
    done = 0;
    for (int k = 0; k < 40 && !done; k++) begin
      @(negedge clk);
      if (cyc == issue + 1) begin
        checkOutput({name, "_sel"}, 64'(s_sel), 64'(exp_sel));
        if (exp_sel != 4'b0000) begin
          checkOutput({name, "_addr"}, s_addr, addr);
          checkOutput({name, "_ctrl"}, 64'({s_rd_ctrl, s_wr_ctrl}),
                      64'({(wr != 3'd0) ? 3'd0 : rd, wr}));
        end
      end
      if (s_sel != 4'b0000) begin
        sel_cycles++;
        checkOutput({name, "_din"}, s_din, din);
      end
      if (mst ? m1_ack : m0_ack) done = 1;
    end
    if (!done) begin
      checks++;
      failures++;
      $display("[TB] FAIL %s_ack_timeout actual=none required=ack", name);
    end
    checkOutput({name, "_selcyc"}, 64'(sel_cycles), 64'((exp_sel != 4'b0000) ? lat - 1 : 0));
    @(posedge clk); #1;
    driveMaster(mst, 1'b0, '0, '0, 3'd0, 3'd0);
  endtask

  initial begin
    int issue;
    rst = 1'b1;
    driveMaster(1'b0, 1'b0, '0, '0, 3'd0, 3'd0);
    driveMaster(1'b1, 1'b0, '0, '0, 3'd0, 3'd0);
    wait_cfg = '{0, 0, 0, 0};
    rd_data  = '{64'h0000_0000_CAFE_0000, 64'hDEAD_BEEF_0000_1234,
                 64'h2222_3333_4444_5555, 64'h9999_8888_7777_6666};
    repeat (3) @(posedge clk);
    @(negedge clk);
    checkOutput("rst_sel", 64'(s_sel), 64'd0);
    checkOutput("rst_s_bus", s_addr | s_din | 64'({s_rd_ctrl, s_wr_ctrl}), 64'd0);
    checkOutput("rst_m_resp", m0_dout | m1_dout | 64'({m0_ack, m1_ack, m0_err, m1_err}), 64'd0);
    @(posedge clk); #1;
    rst = 1'b0;

    applyStimulus("rd_s1", 1'b0, 64'h1000_1008, 64'h0, 3'b011, 3'b000,
                  64'hDEAD_BEEF_0000_1234, 1'b0, 2, 4'b0010);
    wait_cfg[3] = 3;
    applyStimulus("wr_s3", 1'b1, 64'h1000_3000, 64'hA5, 3'b000, 3'b011,
                  64'h0, 1'b0, 5, 4'b1000);
    applyStimulus("rdwr_s3top", 1'b0, 64'h1000_3FFF, 64'h77, 3'b011, 3'b010,
                  64'h0, 1'b0, 5, 4'b1000);
    applyStimulus("miss_hi", 1'b0, 64'h2000_0000, 64'h0, 3'b011, 3'b000, 64'h0, 1'b1, 1, 4'b0000);
    applyStimulus("miss_edge", 1'b1, 64'h1000_4000, 64'h0, 3'b001, 3'b000, 64'h0, 1'b1, 1, 4'b0000);
    applyStimulus("null_op", 1'b0, 64'h1000_0000, 64'h0, 3'b000, 3'b000, 64'h0, 1'b1, 1, 4'b0000);

    // Slave 2 never ready while slave 0 raises a stray ready
    wait_cfg[2] = 1000;
    stray = 4'b0001;
    applyStimulus("timeout", 1'b0, 64'h1000_2000, 64'h0, 3'b011, 3'b000, 64'h0, 1'b1, 10, 4'b0100);
    stray = 4'b0000;
    wait_cfg[2] = 8;
    applyStimulus("ready_at_to", 1'b1, 64'h1000_2010, 64'h0, 3'b011, 3'b000,
                  64'h2222_3333_4444_5555, 1'b0, 10, 4'b0100);

    // Both masters request continuously; the first grant follows last_grant of the previous ack (m1)
    @(posedge clk); #1;
    driveMaster(1'b0, 1'b1, 64'h1000_0000, 64'h0, 3'b001, 3'b000);
    driveMaster(1'b1, 1'b1, 64'h1000_0008, 64'h0, 3'b001, 3'b000);
    issue = cyc;
    for (int k = 0; k < 4; k++)
      sb.push_back('{k[0], 64'h0000_0000_CAFE_0000, 1'b0, issue + 2 + 3 * k});
    for (int k = 0; k < 30 && cyc < issue + 11; k++) @(negedge clk);
    @(posedge clk); #1;
    driveMaster(1'b0, 1'b0, '0, '0, 3'd0, 3'd0);
    driveMaster(1'b1, 1'b0, '0, '0, 3'd0, 3'd0);
    repeat (2) @(posedge clk);
    checkOutput("rr_drained", 64'(sb.size()), 64'd0);

    // Reset during the second WAIT cycle aborts the access without an ack
    wait_cfg[1] = 1000;
    @(posedge clk); #1;
    driveMaster(1'b0, 1'b1, 64'h1000_1000, 64'h0, 3'b011, 3'b000);
    issue = cyc;
    @(negedge clk);
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b1;
    driveMaster(1'b0, 1'b0, '0, '0, 3'd0, 3'd0);
    @(negedge clk);
    checkOutput("prerst_sel", 64'(s_sel), 64'(4'b0010));
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    checkOutput("mrst_sel", 64'(s_sel), 64'd0);
    checkOutput("mrst_s_bus", s_addr | s_din | 64'({s_rd_ctrl, s_wr_ctrl}), 64'd0);
    checkOutput("mrst_m_resp", m0_dout | m1_dout | 64'({m0_ack, m1_ack, m0_err, m1_err}), 64'd0);
    wait_cfg[1] = 0;
    applyStimulus("post_rst", 1'b1, 64'h1000_1010, 64'h0, 3'b011, 3'b000,
                  64'hDEAD_BEEF_0000_1234, 1'b0, 2, 4'b0010);

    repeat (3) @(posedge clk);
    checkOutput("sb_empty", 64'(sb.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/sys_bus_arb.md
Name: sys_bus_arb

Overview:
Parametrised memory-mapped I/O interconnect. It replaces the fixed single-master, combinational system bus with a two-master, N-slave, registered request/acknowledge fabric. Masters are port 0 (data_path MMIO) and port 1 (debug/DMA). It provides round-robin arbitration, base/region address decode, slave wait states, a timeout and an error response. Peripherals such as gpio and uart_top attach as slaves through per-slave select/ready.

Parameters:
NUM_SLAVES, 4, slave count; power of two, >=2; IDX_W = clog2(NUM_SLAVES)
ADDR_W, 64, address width
DATA_W, 64, data width
BUS_BASE, 64'h1000_0000, window base; aligned to 2^(REGION_SHIFT+IDX_W)
REGION_SHIFT, 12, log2 of bytes per slave region
TIMEOUT_CYC, 255, maximum cycles waiting for s_ready

Ports:
clk  in  1  system clock
rst  in  1  synchronous, active-high reset
m0_req  in  1  master 0 request; held until m0_ack
m0_addr  in  ADDR_W  master 0 address
m0_din  in  DATA_W  master 0 write data
m0_rd_ctrl  in  3  master 0 read size/sign code (0 = no read)
m0_wr_ctrl  in  3  master 0 write size code (0 = no write)
m0_ack  out  1  one-cycle completion pulse
m0_dout  out  DATA_W  read data, valid with m0_ack
m0_err  out  1  error flag, valid with m0_ack
m1_*  same set as m0_* for master 1
s_sel  out  NUM_SLAVES  one-hot slave select
s_addr  out  ADDR_W  latched address (full, unmodified)
s_din  out  DATA_W  latched write data
s_rd_ctrl  out  3  latched read control
s_wr_ctrl  out  3  latched write control
s_dout  in  NUM_SLAVES*DATA_W  slave read data, slave i in bits [i*DATA_W +: DATA_W]
s_ready  in  NUM_SLAVES  slave completion, sampled only for the selected slave

Behaviour:
- Reset (synchronous): state IDLE.
  - All outputs 0: acks, errs, douts, s_sel, s_addr, s_din, s_rd_ctrl, s_wr_ctrl.
  - last_grant = 1, so master 0 wins the first contention.
  - Timeout counter = 0.
  - Reset mid-transaction drops s_sel next edge; no ack is ever issued for the aborted request.
- FSM states: IDLE, WAIT, RESP.
- IDLE:
  - Only one master requesting: grant it. Both requesting: grant the master != last_grant.
  - On grant, latch addr/din/rd_ctrl/wr_ctrl and the granted id.
  - Decode: hit iff addr[ADDR_W-1:REGION_SHIFT+IDX_W] == BUS_BASE[same bits]; slave index = addr[REGION_SHIFT+IDX_W-1:REGION_SHIFT].
  - Hit with a non-null op: next state WAIT; s_sel one-hot and s_* driven from the latch.
  - Miss, or null op (rd_ctrl == 0 and wr_ctrl == 0): next state RESP with err = 1 and dout = 0. No slave is strobed.
  - Both rd_ctrl and wr_ctrl nonzero: treated as a write. s_rd_ctrl is forced to 0.
- WAIT:
  - s_* held stable. Counter increments each cycle.
  - s_ready[idx] = 1: capture s_dout slice (write returns 0), err = 0, clear s_sel next edge, go RESP.
  - Counter == TIMEOUT_CYC with no ready: err = 1, dout = 0, clear s_sel, go RESP.
  - Ready on the same cycle as timeout: ready wins, err = 0.
  - s_ready of unselected slaves is ignored.
- RESP:
  - Exactly one cycle: the granted master gets mX_ack = 1 with mX_dout/mX_err. The other master's ack stays 0.
  - last_grant = granted id, counter = 0, go IDLE.
- Latency:
  - req seen in cycle 0 -> s_sel high in cycle 1.
  - Zero-wait slave (ready in cycle 1) -> ack in cycle 2.
  - Each wait cycle adds 1.
  - Miss -> ack in cycle 1.
- Master obligations:
  - Hold req and payload until ack is seen.
  - Deassert req (or present a new request) in the cycle after ack.
  - req high in IDLE after RESP is a new transaction.
- dout/err are registered and change only at RESP. Between acks they are 0.
- Request changes by a non-granted master during WAIT are ignored until IDLE.

Test Plan:
- m0 read, rd_ctrl=3'b011, addr 64'h1000_1008; slave 1 drives 64'hDEAD_BEEF_0000_1234 with ready in the first WAIT cycle -> s_sel=4'b0010 in cycle 1; m0_ack in cycle 2 with that data, err=0.
- m1 write, wr_ctrl=3'b011, addr 64'h1000_3000, din 64'hA5; slave 3 holds ready low 3 cycles -> s_din=64'hA5 stable throughout; m1_ack in cycle 5, err=0.
- m0 and m1 requesting continuously, both targeting slave 0 (zero-wait) -> grant order m0, m1, m0, m1; each ack goes only to its owner.
- m0 read at 64'h2000_0000 (decode miss) -> s_sel never asserts; m0_ack in cycle 1 with err=1, dout=0. Null op at 64'h1000_0000 -> same result.
- TIMEOUT_CYC=8; slave 2 never ready -> s_sel=4'b0100 for 9 cycles, then m0_ack with err=1, dout=0. Ready asserted exactly at count 8 -> err=0.
- rst pulsed in WAIT cycle 2 of a slave 1 access -> next cycle s_sel=0 and all outputs 0; no ack; the following m1 request is served normally.
